// File: rtl/inst_buffer_if.sv
// Bundle between ICache fetch, the instruction buffer and decode.
// ICache offers 0-2 instructions through data_ok1/2; the buffer issues 0-2 in order
// through issue_valid1/2, and every valid issue slot is a completed transfer unless
// dec_stall was high that cycle (dec_stall already masks issue_valid*).
interface inst_buffer_if;
  logic        flush;
  logic        data_ok1;
  logic        data_ok2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] raddr1;
  logic [31:0] raddr2;
  logic [34:0] predict_pkt1;
  logic [34:0] predict_pkt2;
  logic        instbuffer_full;
  logic        dec_stall;
  logic        issue_valid1;
  logic        issue_valid2;
  logic [31:0] issue_inst1;
  logic [31:0] issue_inst2;
  logic [31:0] issue_addr1;
  logic [31:0] issue_addr2;
  logic [34:0] issue_pkt1;
  logic [34:0] issue_pkt2;
  logic        overflow_err;

  modport master (
    output flush, data_ok1, data_ok2, rdata1, rdata2, raddr1, raddr2,
           predict_pkt1, predict_pkt2, dec_stall,
    input  instbuffer_full, issue_valid1, issue_valid2, issue_inst1, issue_inst2,
           issue_addr1, issue_addr2, issue_pkt1, issue_pkt2, overflow_err
  );

  modport slave (
    input  flush, data_ok1, data_ok2, rdata1, rdata2, raddr1, raddr2,
           predict_pkt1, predict_pkt2, dec_stall,
    output instbuffer_full, issue_valid1, issue_valid2, issue_inst1, issue_inst2,
           issue_addr1, issue_addr2, issue_pkt1, issue_pkt2, overflow_err
  );
endinterface

// File: rtl/inst_buffer.sv
// Dual-issue circular instruction FIFO between ICache and decode.
// Entries are {pkt[98:64], addr[63:32], inst[31:0]}; no write-to-issue bypass.
module inst_buffer #(
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 4
) (
  input  logic         clk,
  input  logic         rst,
  inst_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [98:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [1:0]    push_n, acc_n, pop_n;
  logic [CW-1:0] space;
  logic          drop, valid1, valid2, we1, we2;
  logic [AW-1:0] wr_ptr_p1, rd_ptr_p1;
  logic [98:0]   rd_ent1, rd_ent2;

  always_comb begin
    push_n    = {1'b0, bus.data_ok1} + {1'b0, bus.data_ok1 & bus.data_ok2};
    space     = CW'(DEPTH) - count_q;
    drop      = {{(CW-2){1'b0}}, push_n} > space;
    // When dropping, space is below 2, so its low bits are the accepted count
    acc_n     = drop ? space[1:0] : push_n;
    valid1    = (count_q != '0) & ~bus.dec_stall;
    valid2    = (count_q >= CW'(2)) & ~bus.dec_stall;
    pop_n     = {1'b0, valid1} + {1'b0, valid2};
    wr_ptr_p1 = wr_ptr_q + AW'(1);
    rd_ptr_p1 = rd_ptr_q + AW'(1);
    we1       = ~bus.flush & (acc_n != 2'd0);
    we2       = ~bus.flush & (acc_n == 2'd2);
    rd_ent1   = mem_q[rd_ptr_q];
    rd_ent2   = mem_q[rd_ptr_p1];

    rd_ptr_d  = rd_ptr_q + AW'(pop_n);
    wr_ptr_d  = wr_ptr_q + AW'(acc_n);
    count_d   = count_q + CW'(acc_n) - CW'(pop_n);
    ovf_d     = ovf_q | drop;
    // Flush wins over same-cycle push and pop
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage contents need no reset; the count alone qualifies them
  always_ff @(posedge clk) begin
    if (we1) mem_q[wr_ptr_q]  <= {bus.predict_pkt1, bus.raddr1, bus.rdata1};
    if (we2) mem_q[wr_ptr_p1] <= {bus.predict_pkt2, bus.raddr2, bus.rdata2};
  end

  assign bus.issue_valid1    = valid1;
  assign bus.issue_valid2    = valid2;
  assign bus.issue_inst1     = valid1 ? rd_ent1[31:0]  : 32'd0;
  assign bus.issue_addr1     = valid1 ? rd_ent1[63:32] : 32'd0;
  assign bus.issue_pkt1      = valid1 ? rd_ent1[98:64] : 35'd0;
  assign bus.issue_inst2     = valid2 ? rd_ent2[31:0]  : 32'd0;
  assign bus.issue_addr2     = valid2 ? rd_ent2[63:32] : 32'd0;
  assign bus.issue_pkt2      = valid2 ? rd_ent2[98:64] : 35'd0;
  assign bus.instbuffer_full = (CW'(DEPTH) - count_q) < CW'(FULL_MARGIN);
  assign bus.overflow_err    = ovf_q;
endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: a reference model tracks occupancy and queues expected
// entries as they are pushed; each scenario task compares the issue outputs.
module tb_inst_buffer;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  inst_buffer_if bus_if ();

  inst_buffer #(.DEPTH(DEPTH), .FULL_MARGIN(4)) u_dut (.clk(clk), .rst(rst), .bus(bus_if));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [98:0] exp_q[$];
  int          m_count = 0;
  logic        m_ovf = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] next_addr = 32'hbfc00000;
  logic        exp_v1, exp_v2, exp_full;

  task automatic set_in(input logic ok1, input logic ok2, input logic st, input logic fl);
    logic [63:0] r1, r2;
    r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom};
    bus_if.data_ok1     = ok1;
    bus_if.data_ok2     = ok2;
    bus_if.dec_stall    = st;
    bus_if.flush        = fl;
    bus_if.rdata1       = $urandom;
    bus_if.rdata2       = $urandom;
    bus_if.raddr1       = next_addr;
    bus_if.raddr2       = next_addr + 32'd4;
    bus_if.predict_pkt1 = r1[34:0];
    bus_if.predict_pkt2 = r2[34:0];
  endtask

  // Advance one clock and update the reference model from the inputs seen at the edge
  task automatic step();
    int pn, sp, acc, pops;
    logic [98:0] e1, e2;
    pn   = bus_if.data_ok1 ? (bus_if.data_ok2 ? 2 : 1) : 0;
    sp   = DEPTH - m_count;
    acc  = (pn > sp) ? sp : pn;
    pops = bus_if.dec_stall ? 0 : ((m_count >= 2) ? 2 : ((m_count >= 1) ? 1 : 0));
    e1   = {bus_if.predict_pkt1, bus_if.raddr1, bus_if.rdata1};
    e2   = {bus_if.predict_pkt2, bus_if.raddr2, bus_if.rdata2};
    @(posedge clk);
    if (bus_if.flush) begin
      exp_q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
    end else begin
      for (int i = 0; i < pops; i++) void'(exp_q.pop_front());
      if (acc >= 1) exp_q.push_back(e1);
      if (acc == 2) exp_q.push_back(e2);
      m_count = m_count + acc - pops;
      if (pn > sp) m_ovf = 1'b1;
    end
    next_addr = next_addr + 32'(4 * pn);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (bus_if.issue_valid1 !== 1'b0) begin failures++; $display("FAIL rst_valid1 got=%b exp=0", bus_if.issue_valid1); end
    checks++; if (bus_if.issue_inst1 !== 32'd0) begin failures++; $display("FAIL rst_inst1 got=%h exp=0", bus_if.issue_inst1); end
    checks++; if (bus_if.instbuffer_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", bus_if.instbuffer_full); end
    checks++; if (bus_if.overflow_err !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", bus_if.overflow_err); end
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if ({bus_if.issue_valid1, bus_if.issue_valid2, bus_if.issue_pkt2} !== 37'd0) begin failures++; $display("FAIL post_rst_out got=%h exp=0", {bus_if.issue_valid1, bus_if.issue_valid2, bus_if.issue_pkt2}); end
  endtask

  task automatic test_basic();
    next_addr = 32'hbfc00000;
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    bus_if.rdata1 = 32'h11;
    bus_if.rdata2 = 32'h22;
    #1;
    checks++; if (bus_if.issue_valid1 !== 1'b0) begin failures++; $display("FAIL basic_empty_valid got=%b exp=0", bus_if.issue_valid1); end
    step();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if ({bus_if.issue_valid1, bus_if.issue_valid2} !== 2'b11) begin failures++; $display("FAIL basic_valid got=%b exp=11", {bus_if.issue_valid1, bus_if.issue_valid2}); end
    checks++; if (bus_if.issue_inst1 !== 32'h11 || bus_if.issue_inst2 !== 32'h22) begin failures++; $display("FAIL basic_inst got=%h/%h exp=11/22", bus_if.issue_inst1, bus_if.issue_inst2); end
    checks++; if (bus_if.issue_addr1 !== 32'hbfc00000 || bus_if.issue_addr2 !== 32'hbfc00004) begin failures++; $display("FAIL basic_addr got=%h/%h exp=bfc00000/bfc00004", bus_if.issue_addr1, bus_if.issue_addr2); end
    checks++; if (bus_if.issue_pkt1 !== exp_q[0][98:64] || bus_if.issue_pkt2 !== exp_q[1][98:64]) begin failures++; $display("FAIL basic_pkt got=%h/%h exp=%h/%h", bus_if.issue_pkt1, bus_if.issue_pkt2, exp_q[0][98:64], exp_q[1][98:64]); end
    step();
    #1;
    checks++; if (bus_if.issue_valid1 !== 1'b0) begin failures++; $display("FAIL basic_drained got=%b exp=0", bus_if.issue_valid1); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 13; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 1'b0);
      step();
      exp_full = (DEPTH - m_count) < 4;
      checks++; if (bus_if.instbuffer_full !== exp_full) begin failures++; $display("FAIL full_flag count=%0d got=%b exp=%b", m_count, bus_if.instbuffer_full, exp_full); end
      checks++; if (bus_if.overflow_err !== 1'b0) begin failures++; $display("FAIL full_no_ovf count=%0d got=%b exp=0", m_count, bus_if.overflow_err); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b0);
      step();
      checks++; if (bus_if.overflow_err !== m_ovf) begin failures++; $display("FAIL ovf_flag step=%0d got=%b exp=%b", i, bus_if.overflow_err, m_ovf); end
    end
    checks++; if (m_count != 16 || bus_if.instbuffer_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1 count=%0d", bus_if.instbuffer_full, m_count); end
    for (int i = 0; i < 9; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      exp_v1 = m_count >= 1;
      exp_v2 = m_count >= 2;
      checks++; if ({bus_if.issue_valid1, bus_if.issue_valid2} !== {exp_v1, exp_v2}) begin failures++; $display("FAIL ovf_drain_valid got=%b exp=%b", {bus_if.issue_valid1, bus_if.issue_valid2}, {exp_v1, exp_v2}); end
      if (exp_v1) begin checks++; if ({bus_if.issue_pkt1, bus_if.issue_addr1, bus_if.issue_inst1} !== exp_q[0]) begin failures++; $display("FAIL ovf_drain_e1 got=%h exp=%h", {bus_if.issue_pkt1, bus_if.issue_addr1, bus_if.issue_inst1}, exp_q[0]); end end
      if (exp_v2) begin checks++; if ({bus_if.issue_pkt2, bus_if.issue_addr2, bus_if.issue_inst2} !== exp_q[1]) begin failures++; $display("FAIL ovf_drain_e2 got=%h exp=%h", {bus_if.issue_pkt2, bus_if.issue_addr2, bus_if.issue_inst2}, exp_q[1]); end end
      step();
    end
    checks++; if (bus_if.overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus_if.overflow_err); end
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checks++; if (bus_if.overflow_err !== 1'b0) begin failures++; $display("FAIL ovf_flush_clear got=%b exp=0", bus_if.overflow_err); end
  endtask

  task automatic test_wrap();
    logic [31:0] prev_addr;
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 15; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 1'b0);
      step();
    end
    prev_addr = exp_q[0][63:32] - 32'd4;
    // Drain to rd_ptr=15, then stream pairs across the wrap point
    for (int i = 0; i < 48; i++) begin
      if (i < 8) set_in(1'b0, 1'b0, 1'b0, 1'b0);
      else set_in(1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      exp_v1 = m_count >= 1;
      exp_v2 = m_count >= 2;
      checks++; if ({bus_if.issue_valid1, bus_if.issue_valid2} !== {exp_v1, exp_v2}) begin failures++; $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", i, {bus_if.issue_valid1, bus_if.issue_valid2}, {exp_v1, exp_v2}); end
      if (exp_v1) begin
        checks++; if ({bus_if.issue_pkt1, bus_if.issue_addr1, bus_if.issue_inst1} !== exp_q[0]) begin failures++; $display("FAIL wrap_e1 cyc=%0d got=%h exp=%h", i, {bus_if.issue_pkt1, bus_if.issue_addr1, bus_if.issue_inst1}, exp_q[0]); end
        checks++; if (bus_if.issue_addr1 !== prev_addr + 32'd4) begin failures++; $display("FAIL wrap_seq1 cyc=%0d got=%h exp=%h", i, bus_if.issue_addr1, prev_addr + 32'd4); end
        prev_addr = prev_addr + 32'd4;
      end
      if (exp_v2) begin
        checks++; if ({bus_if.issue_pkt2, bus_if.issue_addr2, bus_if.issue_inst2} !== exp_q[1]) begin failures++; $display("FAIL wrap_e2 cyc=%0d got=%h exp=%h", i, {bus_if.issue_pkt2, bus_if.issue_addr2, bus_if.issue_inst2}, exp_q[1]); end
        checks++; if (bus_if.issue_addr2 !== prev_addr + 32'd4) begin failures++; $display("FAIL wrap_seq2 cyc=%0d got=%h exp=%h", i, bus_if.issue_addr2, prev_addr + 32'd4); end
        prev_addr = prev_addr + 32'd4;
      end
      step();
    end
    checks++; if (m_count != 2 || bus_if.overflow_err !== 1'b0) begin failures++; $display("FAIL wrap_end ovf got=%b exp=0 count=%0d", bus_if.overflow_err, m_count); end
  endtask

  task automatic test_no_bypass();
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    set_in(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if ({bus_if.issue_valid1, bus_if.issue_valid2} !== 2'b10) begin failures++; $display("FAIL nobyp_valid got=%b exp=10", {bus_if.issue_valid1, bus_if.issue_valid2}); end
    checks++; if ({bus_if.issue_pkt1, bus_if.issue_addr1, bus_if.issue_inst1} !== exp_q[0]) begin failures++; $display("FAIL nobyp_e1 got=%h exp=%h", {bus_if.issue_pkt1, bus_if.issue_addr1, bus_if.issue_inst1}, exp_q[0]); end
    checks++; if (bus_if.issue_inst2 !== 32'd0) begin failures++; $display("FAIL nobyp_inst2_zero got=%h exp=0", bus_if.issue_inst2); end
    step();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if ({bus_if.issue_valid1, bus_if.issue_valid2} !== 2'b11) begin failures++; $display("FAIL nobyp_next_valid got=%b exp=11", {bus_if.issue_valid1, bus_if.issue_valid2}); end
    checks++; if ({bus_if.issue_pkt2, bus_if.issue_addr2, bus_if.issue_inst2} !== exp_q[1]) begin failures++; $display("FAIL nobyp_e2 got=%h exp=%h", {bus_if.issue_pkt2, bus_if.issue_addr2, bus_if.issue_inst2}, exp_q[1]); end
    step();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b0);
      step();
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    checks++; if ({bus_if.issue_valid1, bus_if.issue_valid2} !== 2'b11) begin failures++; $display("FAIL flush_preissue got=%b exp=11", {bus_if.issue_valid1, bus_if.issue_valid2}); end
    step();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if ({bus_if.issue_valid1, bus_if.issue_valid2, bus_if.instbuffer_full} !== 3'b000) begin failures++; $display("FAIL flush_empty got=%b exp=000", {bus_if.issue_valid1, bus_if.issue_valid2, bus_if.instbuffer_full}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0));
      #1;
      exp_v1   = (m_count >= 1) && !bus_if.dec_stall;
      exp_v2   = (m_count >= 2) && !bus_if.dec_stall;
      exp_full = (DEPTH - m_count) < 4;
      checks++; if ({bus_if.issue_valid1, bus_if.issue_valid2} !== {exp_v1, exp_v2}) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, {bus_if.issue_valid1, bus_if.issue_valid2}, {exp_v1, exp_v2}); end
      checks++; if ({bus_if.instbuffer_full, bus_if.overflow_err} !== {exp_full, m_ovf}) begin failures++; $display("FAIL rand_flags cyc=%0d got=%b exp=%b", i, {bus_if.instbuffer_full, bus_if.overflow_err}, {exp_full, m_ovf}); end
      if (exp_v1) begin checks++; if ({bus_if.issue_pkt1, bus_if.issue_addr1, bus_if.issue_inst1} !== exp_q[0]) begin failures++; $display("FAIL rand_e1 cyc=%0d got=%h exp=%h", i, {bus_if.issue_pkt1, bus_if.issue_addr1, bus_if.issue_inst1}, exp_q[0]); end end
      if (exp_v2) begin checks++; if ({bus_if.issue_pkt2, bus_if.issue_addr2, bus_if.issue_inst2} !== exp_q[1]) begin failures++; $display("FAIL rand_e2 cyc=%0d got=%h exp=%h", i, {bus_if.issue_pkt2, bus_if.issue_addr2, bus_if.issue_inst2}, exp_q[1]); end end
      step();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b0);
      step();
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if ({bus_if.issue_valid1, bus_if.instbuffer_full, bus_if.overflow_err} !== 3'b111) begin failures++; $display("FAIL arst_pre got=%b exp=111", {bus_if.issue_valid1, bus_if.instbuffer_full, bus_if.overflow_err}); end
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    checks++; if ({bus_if.issue_valid1, bus_if.issue_valid2, bus_if.instbuffer_full, bus_if.overflow_err} !== 4'b0000) begin failures++; $display("FAIL arst_flags got=%b exp=0000", {bus_if.issue_valid1, bus_if.issue_valid2, bus_if.instbuffer_full, bus_if.overflow_err}); end
    checks++; if ({bus_if.issue_inst1, bus_if.issue_addr1, bus_if.issue_pkt1} !== 99'd0) begin failures++; $display("FAIL arst_data got=%h exp=0", {bus_if.issue_inst1, bus_if.issue_addr1, bus_if.issue_pkt1}); end
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if ({bus_if.issue_valid1, bus_if.overflow_err} !== 2'b00) begin failures++; $display("FAIL arst_after got=%b exp=00", {bus_if.issue_valid1, bus_if.overflow_err}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_overflow();
    test_wrap();
    test_no_bypass();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
